// File: rtl/holy_axil_ram.sv
// AXI-lite word-addressed RAM responder with independent write and read FSMs.
// Optional macro HOLY_AXIL_RAM_ERR_RESP_EN enables SLVERR for out-of-window addresses.
module holy_axil_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HALF, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_RESP}         r_state_e;

  logic [31:0] mem_q [DEPTH_WORDS];

  w_state_e    w_state_q, w_state_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  r_state_e    r_state_q, r_state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic             aw_hs_c, w_hs_c, ar_hs_c;
  logic             aw_held_c, w_held_c;
  logic [31:0]      wr_addr_c, wr_data_c;
  logic [3:0]       wr_strb_c;
  logic [IDX_W-1:0] wr_idx_c, rd_idx_c;
  logic             wr_ok_c, rd_ok_c;
  logic             wr_commit_c, mem_we_c;

  assign aw_hs_c = s_axi_awvalid && awready_q;
  assign w_hs_c  = s_axi_wvalid  && wready_q;
  assign ar_hs_c = s_axi_arvalid && arready_q;

  // In W_HALF the already-accepted channel comes from the latch, the other live
  assign aw_held_c = (w_state_q == W_HALF) && !awready_q;
  assign w_held_c  = (w_state_q == W_HALF) && !wready_q;
  assign wr_addr_c = aw_held_c ? awaddr_q : s_axi_awaddr;
  assign wr_data_c = w_held_c  ? wdata_q  : s_axi_wdata;
  assign wr_strb_c = w_held_c  ? wstrb_q  : s_axi_wstrb;

  assign wr_idx_c = IDX_W'((wr_addr_c - BASE_ADDR) >> 2);
  assign rd_idx_c = IDX_W'((s_axi_araddr - BASE_ADDR) >> 2);

`ifdef HOLY_AXIL_RAM_ERR_RESP_EN
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  assign wr_ok_c = ({1'b0, wr_addr_c - BASE_ADDR} < SPAN);
  assign rd_ok_c = ({1'b0, s_axi_araddr - BASE_ADDR} < SPAN);
`else
  assign wr_ok_c = 1'b1;
  assign rd_ok_c = 1'b1;
`endif

  assign mem_we_c = wr_commit_c && wr_ok_c;

  // Write FSM next-state
  always_comb begin
    w_state_d   = w_state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wr_commit_c = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) begin
          wr_commit_c = 1'b1;
        end else if (aw_hs_c) begin
          awaddr_d  = s_axi_awaddr;
          awready_d = 1'b0;
          w_state_d = W_HALF;
        end else if (w_hs_c) begin
          wdata_d   = s_axi_wdata;
          wstrb_d   = s_axi_wstrb;
          wready_d  = 1'b0;
          w_state_d = W_HALF;
        end
      end
      W_HALF: begin
        if (aw_hs_c || w_hs_c) begin
          wr_commit_c = 1'b1;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
    if (wr_commit_c) begin
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
      awready_d = 1'b0;
      wready_d  = 1'b0;
      w_state_d = W_RESP;
    end
  end

  // Read FSM next-state; mem_q read here sees pre-write contents on collision
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          rdata_d   = rd_ok_c ? mem_q[rd_idx_c] : 32'h0;
          rresp_d   = rd_ok_c ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= 32'h0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage has no reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_c[b]) begin
          mem_q[wr_idx_c][8*b +: 8] <= wr_data_c[8*b +: 8];
        end
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_holy_axil_ram.sv
// Scoreboard bench for holy_axil_ram: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them as the DUT hands them over.
module tb_holy_axil_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [1:0]  b_exp [$];
  logic [33:0] r_exp [$];

  holy_axil_ram dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: one negedge with valid&&ready means one handshake at the next posedge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bvalid && bready) begin
      if (b_exp.size() == 0) chk("b_unexpected", 34'(bvalid), 34'(0));
      else chk("bresp", 34'(bresp), 34'(b_exp.pop_front()));
    end
    if (rst_n === 1'b1 && rvalid && rready) begin
      if (r_exp.size() == 0) chk("r_unexpected", 34'(rvalid), 34'(0));
      else chk("rresp_rdata", {rresp, rdata}, r_exp.pop_front());
    end
  end

  task automatic wait_idle_w;
    int n;
    for (n = 0; n < 20 && !(awready && wready); n++) tick;
    if (n == 20) chk("w_ready_timeout", 34'(awready && wready), 34'(1));
  endtask

  task automatic wait_idle_r;
    int n;
    for (n = 0; n < 20 && !arready; n++) tick;
    if (n == 20) chk("ar_ready_timeout", 34'(arready), 34'(1));
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er);
    wait_idle_w;
    b_exp.push_back(er);
    awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("b_latency", 34'(bvalid), 34'(1));
    tick;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] er);
    wait_idle_r;
    r_exp.push_back({er, d});
    araddr = a; rready = 1'b1; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    chk("r_latency", 34'(rvalid), 34'(1));
    tick;
    chk("r_idle_after", 34'(arready), 34'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, 34'(awready), 34'(1));
    chk({tag, "_wready"},  34'(wready),  34'(1));
    chk({tag, "_arready"}, 34'(arready), 34'(1));
    chk({tag, "_bvalid"},  34'(bvalid),  34'(0));
    chk({tag, "_rvalid"},  34'(rvalid),  34'(0));
    chk({tag, "_bresp"},   34'(bresp),   34'(0));
    chk({tag, "_rresp"},   34'(rresp),   34'(0));
    chk({tag, "_rdata"},   34'(rdata),   34'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; araddr = 32'h0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (3) tick;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick;

    // Same-cycle AW+W then readback
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    axi_read (32'h10, 32'hDEADBEEF, 2'b00);

    // W first, AW three cycles later, into a preloaded word
    axi_write(32'h20, 32'hAABBCCDD, 4'hF, 2'b00);
    b_exp.push_back(2'b00);
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
    tick;
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("gap_wready", 34'(wready), 34'(0));
      chk("gap_awready", 34'(awready), 34'(1));
      tick;
    end
    chk("gap_wready", 34'(wready), 34'(0));
    awaddr = 32'h20; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    chk("split_w_b", 34'(bvalid), 34'(1));
    tick;
    axi_read(32'h20, 32'hAA22CC44, 2'b00);

    // AW first, then W with sparse strobe
    b_exp.push_back(2'b00);
    awaddr = 32'h10; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    chk("half_awready", 34'(awready), 34'(0));
    chk("half_wready", 34'(wready), 34'(1));
    wdata = 32'h00FF00FF; wstrb = 4'b1010; wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    chk("split_aw_b", 34'(bvalid), 34'(1));
    tick;
    // Zero strobe writes nothing but still responds
    axi_write(32'h10, 32'hFFFFFFFF, 4'h0, 2'b00);
    axi_read (32'h10, 32'h00AD00EF, 2'b00);

    // Backpressure on both response channels
    b_exp.push_back(2'b00);
    r_exp.push_back({2'b00, 32'h00AD00EF});
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h30; wdata = 32'h12345678; wstrb = 4'hF; araddr = 32'h10;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick;
    awaddr = 32'h34; araddr = 32'h14;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", 34'(bvalid), 34'(1));
      chk("bp_rvalid", 34'(rvalid), 34'(1));
      chk("bp_bresp", 34'(bresp), 34'(0));
      chk("bp_rdata", 34'(rdata), 34'(32'h00AD00EF));
      chk("bp_no_accept", 34'({awready, wready, arready}), 34'(0));
      tick;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    tick;
    chk("bp_release_idle", 34'({awready, wready, arready, bvalid, rvalid}), 34'(5'b11100));
    axi_read(32'h30, 32'h12345678, 2'b00);

    // Write commit colliding with AR to the same word
    axi_write(32'h40, 32'h3, 4'hF, 2'b00);
    b_exp.push_back(2'b00);
    r_exp.push_back({2'b00, 32'h3});
    awaddr = 32'h40; wdata = 32'h5; wstrb = 4'hF; araddr = 32'h40;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("coll_valids", 34'({bvalid, rvalid}), 34'(2'b11));
    tick;
    axi_read(32'h40, 32'h5, 2'b00);

    // One word past the window
    axi_write(32'h0, 32'hCAFEF00D, 4'hF, 2'b00);
`ifdef HOLY_AXIL_RAM_ERR_RESP_EN
    axi_write(32'h1000, 32'h0BADBEEF, 4'hF, 2'b10);
    axi_read (32'h0,    32'hCAFEF00D, 2'b00);
    axi_read (32'h1000, 32'h0,        2'b10);
`else
    axi_write(32'h1000, 32'h0BADBEEF, 4'hF, 2'b00);
    axi_read (32'h0,    32'h0BADBEEF, 2'b00);
    axi_read (32'h1000, 32'h0BADBEEF, 2'b00);
`endif

    // Reset while write is half-done and a read response is pending
    awaddr = 32'h50; awvalid = 1'b1; bready = 1'b1;
    tick;
    awvalid = 1'b0;
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
    tick;
    arvalid = 1'b0;
    chk("pre_rst_state", 34'({awready, wready, rvalid}), 34'(3'b011));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick;
    tick;
    rst_n = 1'b1;
    rready = 1'b1;
    tick;
    // Latched AW must be gone: a lone W now only half-completes
    b_exp.push_back(2'b00);
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    chk("post_rst_half", 34'({bvalid, awready, wready}), 34'(3'b010));
    awaddr = 32'h60; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    chk("post_rst_b", 34'(bvalid), 34'(1));
    tick;
    axi_read(32'h60, 32'h77, 2'b00);
    axi_read(32'h10, 32'h00AD00EF, 2'b00);
    axi_read(32'h40, 32'h5, 2'b00);

    tick;
    chk("b_queue_drained", 34'(b_exp.size()), 34'(0));
    chk("r_queue_drained", 34'(r_exp.size()), 34'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
